// File: rtl/pipe_ctrl_if.sv
// Bundle between the pipeline controller and the 5-stage core: stall/jump/trap
// requests in, stall/flush/redirect and the single CSR write port out.
interface pipe_ctrl_if #(
    parameter int XLEN   = 32,
    parameter int CSR_AW = 12
);
    logic              stallreq_id_i;
    logic              stallreq_ex_i;
    logic              stallreq_mem_i;
    logic              jump_req_i;
    logic [XLEN-1:0]   jump_addr_i;
    logic              exc_req_i;
    logic [XLEN-1:0]   exc_cause_i;
    logic              mret_i;
    logic              irq_i;
    logic              mem_valid_i;
    logic [XLEN-1:0]   pc_mem_i;
    logic [XLEN-1:0]   mstatus_i;
    logic [XLEN-1:0]   mtvec_i;
    logic [XLEN-1:0]   mepc_i;

    logic [5:0]        stall_o;
    logic [4:0]        flush_o;
    logic              redirect_o;
    logic [XLEN-1:0]   redirect_addr_o;
    logic              csr_we_o;
    logic [CSR_AW-1:0] csr_waddr_o;
    logic [XLEN-1:0]   csr_wdata_o;
    logic              trap_busy_o;

    modport master (
        input  stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
        input  jump_req_i, jump_addr_i,
        input  exc_req_i, exc_cause_i, mret_i, irq_i, mem_valid_i,
        input  pc_mem_i, mstatus_i, mtvec_i, mepc_i,
        output stall_o, flush_o, redirect_o, redirect_addr_o,
        output csr_we_o, csr_waddr_o, csr_wdata_o, trap_busy_o
    );

    modport slave (
        output stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
        output jump_req_i, jump_addr_i,
        output exc_req_i, exc_cause_i, mret_i, irq_i, mem_valid_i,
        output pc_mem_i, mstatus_i, mtvec_i, mepc_i,
        input  stall_o, flush_o, redirect_o, redirect_addr_o,
        input  csr_we_o, csr_waddr_o, csr_wdata_o, trap_busy_o
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline controller: stall/flush generation, jump redirect, and the
// machine-mode trap entry/mret sequencer driving one CSR write port.
module pipe_ctrl #(
    parameter int XLEN   = 32,
    parameter int CSR_AW = 12
) (
    input  logic           clk,
    input  logic           rst_n,
    pipe_ctrl_if.master    bus
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        W_EPC   = 3'd1,
        W_CAUSE = 3'd2,
        W_STAT  = 3'd3,
        W_MRET  = 3'd4
    } state_t;

    localparam logic [CSR_AW-1:0] ADDR_MSTATUS = CSR_AW'(12'h300);
    localparam logic [CSR_AW-1:0] ADDR_MEPC    = CSR_AW'(12'h341);
    localparam logic [CSR_AW-1:0] ADDR_MCAUSE  = CSR_AW'(12'h342);
    localparam logic [XLEN-1:0]   IRQ_CAUSE    = XLEN'(32'h8000_000B);

    state_t          state_q, state_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic [XLEN-1:0] cause_q, cause_d;
    logic [XLEN-1:0] mstat_q, mstat_d;

    logic irq_ev;
    logic trap_ev;

    assign irq_ev  = bus.irq_i & bus.mstatus_i[3] & bus.mem_valid_i;
    assign trap_ev = bus.exc_req_i | bus.mret_i | irq_ev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            epc_q   <= '0;
            cause_q <= '0;
            mstat_q <= '0;
        end else begin
            state_q <= state_d;
            epc_q   <= epc_d;
            cause_q <= cause_d;
            mstat_q <= mstat_d;
        end
    end

    always_comb begin
        state_d             = state_q;
        epc_d               = epc_q;
        cause_d             = cause_q;
        mstat_d             = mstat_q;
        bus.stall_o         = '0;
        bus.flush_o         = '0;
        bus.redirect_o      = 1'b0;
        bus.redirect_addr_o = '0;
        bus.csr_we_o        = 1'b0;
        bus.csr_waddr_o     = '0;
        bus.csr_wdata_o     = '0;
        bus.trap_busy_o     = (state_q != IDLE);

        unique case (state_q)
            IDLE: begin
                // A mem-stage wait blocks trap acceptance, so the faulting
                // instruction is still in mem when the event is retried.
                if (trap_ev && !bus.stallreq_mem_i) begin
                    bus.flush_o = 5'b11111;
                    epc_d       = bus.pc_mem_i;
                    mstat_d     = bus.mstatus_i;
                    if (bus.exc_req_i) begin
                        cause_d = bus.exc_cause_i;
                        state_d = W_EPC;
                    end else if (bus.mret_i) begin
                        state_d = W_MRET;
                    end else begin
                        cause_d = IRQ_CAUSE;
                        state_d = W_EPC;
                    end
                end else if (bus.jump_req_i && !bus.stallreq_ex_i && !bus.stallreq_mem_i) begin
                    bus.flush_o         = 5'b00111;
                    bus.redirect_o      = 1'b1;
                    bus.redirect_addr_o = bus.jump_addr_i;
                end else if (bus.stallreq_mem_i) begin
                    bus.stall_o = 6'b011111;
                end else if (bus.stallreq_ex_i) begin
                    bus.stall_o = 6'b001111;
                end else if (bus.stallreq_id_i) begin
                    bus.stall_o = 6'b000111;
                end
            end
            W_EPC: begin
                bus.stall_o     = 6'b000011;
                bus.csr_we_o    = 1'b1;
                bus.csr_waddr_o = ADDR_MEPC;
                bus.csr_wdata_o = epc_q;
                state_d         = W_CAUSE;
            end
            W_CAUSE: begin
                bus.stall_o     = 6'b000011;
                bus.csr_we_o    = 1'b1;
                bus.csr_waddr_o = ADDR_MCAUSE;
                bus.csr_wdata_o = cause_q;
                state_d         = W_STAT;
            end
            W_STAT: begin
                bus.stall_o         = 6'b000011;
                bus.csr_we_o        = 1'b1;
                bus.csr_waddr_o     = ADDR_MSTATUS;
                bus.csr_wdata_o     = mstat_q;
                bus.csr_wdata_o[7]  = mstat_q[3];
                bus.csr_wdata_o[3]  = 1'b0;
                bus.redirect_o      = 1'b1;
                bus.redirect_addr_o = {bus.mtvec_i[XLEN-1:2], 2'b00};
                state_d             = IDLE;
            end
            W_MRET: begin
                bus.stall_o         = 6'b000011;
                bus.csr_we_o        = 1'b1;
                bus.csr_waddr_o     = ADDR_MSTATUS;
                bus.csr_wdata_o     = mstat_q;
                bus.csr_wdata_o[3]  = mstat_q[7];
                bus.csr_wdata_o[7]  = 1'b1;
                bus.redirect_o      = 1'b1;
                bus.redirect_addr_o = bus.mepc_i;
                state_d             = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline controller for the 5-stage core (pc/if/id/ex/mem/wb). It turns per-stage stall requests into the stall_o[5:0] vector and turns branch/jump and trap events into the flush_o[4:0] vector consumed by every pipeline register (if_id, id_ex, ex_mem, mem_wb). It also provides a PC redirect and sequences machine-mode trap entry/exit through a small FSM that writes mepc/mcause/mstatus over a single CSR write port.

Parameters:
XLEN, 32, data/PC width
CSR_AW, 12, CSR address width

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
stallreq_id_i  in  1  load-use hazard from id
stallreq_ex_i  in  1  multi-cycle op busy in ex
stallreq_mem_i  in  1  data bus wait in mem
jump_req_i  in  1  taken branch/jump resolved in ex
jump_addr_i  in  XLEN  jump target
exc_req_i  in  1  synchronous exception on the mem-stage instruction
exc_cause_i  in  XLEN  exception mcause value
mret_i  in  1  mret in mem stage
irq_i  in  1  external interrupt, level
mem_valid_i  in  1  mem stage holds a real instruction
pc_mem_i  in  XLEN  PC of the mem-stage instruction
mstatus_i  in  XLEN  current mstatus
mtvec_i  in  XLEN  current mtvec
mepc_i  in  XLEN  current mepc
stall_o  out  6  stall[k]: hold stage k (0=pc … 5=wb)
flush_o  out  5  flush[k]: clear register after stage k
redirect_o  out  1  one-cycle PC redirect strobe
redirect_addr_o  out  XLEN  redirect target
csr_we_o  out  1  CSR write enable
csr_waddr_o  out  CSR_AW  CSR write address
csr_wdata_o  out  XLEN  CSR write data
trap_busy_o  out  1  FSM not IDLE

Behaviour:
- Clock and reset: one clock, clk; asynchronous active-low reset, rst_n. Reset forces state IDLE and all outputs and internal latches to 0.
- Stall encoding, applied in IDLE with no accepted event. Highest requester wins:
  - mem request -> 6'b011111
  - ex request -> 6'b001111
  - id request -> 6'b000111
  - none -> 0
- Pipeline registers insert a bubble when stall[k]&!stall[k+1].
- Event priority in IDLE: exc_req_i > mret_i > irq (irq_i & mstatus_i[3] & mem_valid_i) > jump_req_i.
  - A trap event (exc/mret/irq) with stallreq_mem_i=1 is not accepted. Normal stall applies and the event is re-evaluated next cycle.
  - A jump with stallreq_ex_i or stallreq_mem_i set is ignored that cycle. Ex re-asserts it.
- Jump acceptance, same cycle (combinational):
  - redirect_o=1, redirect_addr_o=jump_addr_i
  - flush_o=5'b00111, stall_o=0
  - This overrides stallreq_id_i.
- Trap acceptance cycle:
  - flush_o=5'b11111; the mem-stage instruction and all younger ones never commit.
  - stall_o=0.
  - Latch pc_mem_i, the cause and mstatus_i.
  - Irq cause = 32'h8000000B.
- FSM states IDLE, W_EPC, W_CAUSE, W_STAT, W_MRET.
  - Exc/irq: IDLE -> W_EPC -> W_CAUSE -> W_STAT -> IDLE.
  - Mret: IDLE -> W_MRET -> IDLE.
- One CSR write per state, registered, starting the cycle after acceptance:
  - W_EPC: addr 0x341, data = latched PC.
  - W_CAUSE: addr 0x342, data = latched cause.
  - W_STAT: addr 0x300, data = latched mstatus with bit7 (MPIE) = old bit3 and bit3 (MIE) = 0.
  - W_MRET: addr 0x300, data = latched mstatus with bit3 = old bit7 and bit7 = 1.
- Redirect is asserted in the last state, together with its CSR write:
  - W_STAT: redirect_o=1, addr = {mtvec_i[XLEN-1:2],2'b00}.
  - W_MRET: redirect_o=1, addr = mepc_i.
- In every non-IDLE state:
  - stall_o=6'b000011, flush_o=0.
  - All stall requests, jumps and new events are ignored.
  - trap_busy_o=1.
- Trap entry latency: accept + 3 cycles; redirect in cycle 3. Mret latency: accept + 1.
- Reset mid-FSM: immediate return to IDLE. A CSR write in flight is dropped, with no retry.

Test Plan:
- stallreq_id_i=1 alone -> stall_o=6'b000111, flush_o=0; adding stallreq_mem_i=1 the same cycle -> stall_o=6'b011111.
- jump_req_i=1, jump_addr_i=32'h80 with stallreq_id_i=1 -> same cycle redirect_o=1, addr 0x80, flush_o=5'b00111, stall_o=0. Repeat with stallreq_ex_i=1 -> no redirect.
- exc_req_i=1, cause=2, pc_mem_i=0x100, mstatus_i=0x8, mtvec_i=0x203 -> flush_o=5'b11111, then writes (0x341,0x100), (0x342,2), (0x300,0x80) on successive cycles; redirect to 0x200 on the third; trap_busy_o high for exactly 3 cycles.
- irq_i=1 with mstatus_i[3]=0 -> no trap. With mstatus_i[3]=1, mem_valid_i=1 and exc_req_i=1 simultaneously -> mcause written = exc_cause_i, not 0x8000000B.
- mret_i=1, mstatus_i=0x80, mepc_i=0x104 -> next cycle write (0x300,0x88) and redirect to 0x104.
- exc_req_i=1 with stallreq_mem_i=1 for 2 cycles -> stall_o=6'b011111 and no CSR write; accepted on cycle 3. rst_n low in W_CAUSE -> state IDLE, all outputs 0.
